// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: occupancy states,
// default payload constants and performance-counter width.
package pipe_pkg;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } stage_state_e;

   // Payload presented by an empty stage register after reset or flush.
   localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_3000;
   localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

   localparam int CNT_W = 32;

endpackage : pipe_pkg

// File: rtl/pipe_sat_cnt.sv
// 32-bit saturating event counter with a synchronous clear.
// Used for the stage-register stall/bubble counters under PIPE_STAGE_PERF_EN.
module pipe_sat_cnt
   import pipe_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count = cnt_q;

endmodule : pipe_sat_cnt

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: valid/ready handshake, flush, one-entry skid.
// Define PIPE_STAGE_PERF_EN to add the stall_cnt/bubble_cnt performance counters.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int                 PC_W      = 32,
   parameter int                 INSTR_W   = 32,
   parameter int                 SIDE_W    = 1,
   parameter logic [PC_W-1:0]    RESET_PC  = PC_W'(DEFAULT_RESET_PC),
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(DEFAULT_NOP_INSTR)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [PC_W-1:0]    in_pc,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [SIDE_W-1:0]  in_side,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PC_W-1:0]    out_pc,
   output logic [INSTR_W-1:0] out_instr,
   output logic [SIDE_W-1:0]  out_side
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic [CNT_W-1:0]   bubble_cnt
`endif
);

   localparam int PAY_W = PC_W + INSTR_W + SIDE_W;
   localparam logic [PAY_W-1:0] PAY_RESET = {RESET_PC, NOP_INSTR, {SIDE_W{1'b0}}};

   stage_state_e     state_d,    state_q;
   logic [PAY_W-1:0] main_d,     main_q;
   logic [PAY_W-1:0] skid_d,     skid_q;
   logic             in_ready_d, in_ready_q;

   logic [PAY_W-1:0] in_pay;
   logic             acc;
   logic             con;

   assign in_pay    = {in_pc, in_instr, in_side};
   assign out_valid = (state_q != S_EMPTY);
   assign acc       = in_valid & in_ready_q;
   assign con       = out_valid & out_ready;

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;

      unique case (state_q)
         S_EMPTY: begin
            if (acc) begin
               state_d = S_ONE;
               main_d  = in_pay;
            end
         end
         S_ONE: begin
            if (acc && con) begin
               main_d = in_pay;
            end else if (acc) begin
               state_d = S_TWO;
               skid_d  = in_pay;
            end else if (con) begin
               state_d = S_EMPTY;
               main_d  = PAY_RESET;
            end
         end
         S_TWO: begin
            // in_ready is low here, so only the skid-to-main shift can happen.
            if (con) begin
               state_d = S_ONE;
               main_d  = skid_q;
               skid_d  = PAY_RESET;
            end
         end
         default: begin
            state_d = S_EMPTY;
            main_d  = PAY_RESET;
            skid_d  = PAY_RESET;
         end
      endcase

      if (flush) begin
         state_d = S_EMPTY;
         main_d  = PAY_RESET;
         skid_d  = PAY_RESET;
      end

      // Registered ready: deciding from next state keeps back-pressure off any comb path.
      in_ready_d = (state_d != S_TWO);
   end

   // NOTE: the payload slots are small and observable on out_*, so they are reset too.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_EMPTY;
         main_q     <= PAY_RESET;
         skid_q     <= PAY_RESET;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready                      = in_ready_q;
   assign {out_pc, out_instr, out_side} = main_q;

`ifdef PIPE_STAGE_PERF_EN
   pipe_sat_cnt u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (1'b0),
      .inc   (out_valid & ~out_ready),
      .count (stall_cnt)
   );

   pipe_sat_cnt u_bubble_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (1'b0),
      .inc   (~out_valid & out_ready),
      .count (bubble_cnt)
   );
`endif

endmodule : pipe_stage_reg
